pci_tgt_seq: RTL and testbench
==============================

PCI_TGT_SEQ -- requirements
Module: pci_tgt_seq

Interface
REQ-001 SHALL have parameter RETRY_LIMIT, default 16, meaning the number of clocks from the first data-phase clock without TRDY# before a retry is issued (range 2..31).
REQ-002 SHALL have port clk  input  1  PCI clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port frame_n  input  1  sampled PCI FRAME#, active-low.
REQ-005 SHALL have port irdy_n  input  1  sampled PCI IRDY#, active-low.
REQ-006 SHALL have port card_hit  input  1  address decode hit from the config space, valid in the decode clock.
REQ-007 SHALL have port acc_cfg  input  1  current access is a configuration cycle.
REQ-008 SHALL have port cfg_drdy  input  1  config register data ready.
REQ-009 SHALL have port be_drdy  input  1  memory/IO backend data ready.
REQ-010 SHALL have port t_abort  input  1  backend requests target abort.
REQ-011 SHALL have port first_cyc  output  1  high in the address-phase clock only.
REQ-012 SHALL have port acc_end  output  1  one-clock pulse when the transaction ends.
REQ-013 SHALL have port xfer  output  1  high in each clock where trdy_n=0 and irdy_n=0 (data transferred).
REQ-014 SHALL have ports devsel_n, trdy_n, stop_n  output  1 each  registered PCI target signals, active-low.
REQ-015 SHALL have port tgt_oe  output  1  output enable for devsel_n/trdy_n/stop_n.

Function
REQ-016 SHALL implement states IDLE, DECODE, BUSY, DATA, BACKOFF, TURN_AR, encoded in the shared package.
REQ-017 SHALL, in IDLE, on frame_n=0 with the previous frame_n=1, assert first_cyc combinationally and go to DECODE.
REQ-018 SHALL, in DECODE, go to DATA with devsel_n=0 and tgt_oe=1 if card_hit=1, else go to BUSY.
REQ-019 SHALL stay in BUSY until frame_n=1 and irdy_n=1, then go to IDLE, driving no outputs.
REQ-020 SHALL, in DATA, select drdy = acc_cfg ? cfg_drdy : be_drdy and drive trdy_n=0 next clock when drdy=1 and t_abort=0.
REQ-021 SHALL count DATA clocks without a transfer in a 5-bit counter cleared on each transfer, saturating at 31.
REQ-022 SHALL, when the count reaches RETRY_LIMIT before the first transfer, drive stop_n=0, trdy_n=1 (retry) and go to BACKOFF.
REQ-023 SHALL, on t_abort=1 in DATA, drive stop_n=0, devsel_n=1, trdy_n=1 (target abort) and go to BACKOFF; t_abort takes priority over drdy and retry in the same clock.
REQ-024 SHALL, on a transfer with acc_cfg=1 and frame_n=0, drive stop_n=0 (disconnect after one data phase) and go to BACKOFF.
REQ-025 SHALL, on a transfer with frame_n=1, go to TURN_AR.
REQ-026 SHALL hold stop_n=0 in BACKOFF until frame_n=1 and a clock with irdy_n=0, then go to TURN_AR.
REQ-027 SHALL, in TURN_AR, drive devsel_n=trdy_n=stop_n=1 with tgt_oe=1 for one clock, pulse acc_end, then clear tgt_oe and go to IDLE.
REQ-028 SHALL never assert trdy_n=0 and stop_n=0 in the same clock except for a disconnect-with-data transfer (REQ-024 clock).

Reset
REQ-029 SHALL, while rst=1, force IDLE, counter=0, devsel_n=trdy_n=stop_n=1, tgt_oe=0, first_cyc=acc_end=xfer=0.
REQ-030 SHALL, on reset mid-transaction, release the bus immediately (tgt_oe=0) with no TURN_AR clock and no acc_end pulse.

Structure
REQ-031 SHALL place the state encoding and the RETRY_LIMIT default in the shared PCI package.
REQ-032 SHALL be one module with the wait counter inline; no sub-module.

Verification
REQ-033 Cfg read, card_hit=1, cfg_drdy=1 in clock 3, frame_n=1 at data phase -> devsel_n low from clock 2, one xfer, acc_end one clock after xfer, tgt_oe low one clock later.
REQ-034 Memory burst of 4, be_drdy=1 throughout, irdy_n low -> 4 consecutive xfer pulses, no stop_n, TURN_AR after the 4th.
REQ-035 be_drdy held 0 -> stop_n low exactly RETRY_LIMIT (16) clocks after DATA entry, zero xfer pulses, hold until frame_n=1.
REQ-036 t_abort=1 with be_drdy=1 in the same clock -> devsel_n=1, stop_n=0, trdy_n=1, no xfer.
REQ-037 card_hit=0 -> outputs never enabled, BUSY until frame_n=irdy_n=1, then IDLE.
REQ-038 rst=1 in the second data clock of a burst -> tgt_oe=0 and all outputs high asynchronously, acc_end stays 0.

Source files
------------

// File: rtl/pci_tgt_seq_pkg.sv
// Shared definitions for the PCI target sequencer.
// Contents:
//   RETRY_LIMIT_DEF  default number of wait clocks before a retry is issued
//   CNT_W / CNT_MAX  width and saturation value of the data-phase wait counter
//   tgt_state_e      sequencer state encoding
//   tgt_drv_t        bundle of the registered target bus drivers
//   sat_inc()        saturating increment for the wait counter
package pci_tgt_seq_pkg;

  localparam int unsigned RETRY_LIMIT_DEF = 16;
  localparam int unsigned CNT_W           = 5;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    BUSY    = 3'd2,
    DATA    = 3'd3,
    BACKOFF = 3'd4,
    TURN_AR = 3'd5
  } tgt_state_e;

  // Registered target drivers; the *_n fields are PCI active-low signals.
  typedef struct packed {
    logic devsel_n;
    logic trdy_n;
    logic stop_n;
    logic oe;
  } tgt_drv_t;

  // Bus released: nothing asserted, drivers tri-stated.
  localparam tgt_drv_t DRV_OFF  = '{devsel_n: 1'b1, trdy_n: 1'b1, stop_n: 1'b1, oe: 1'b0};
  // Turnaround: all signals driven inactive for one clock before release.
  localparam tgt_drv_t DRV_TURN = '{devsel_n: 1'b1, trdy_n: 1'b1, stop_n: 1'b1, oe: 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : CNT_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/pci_tgt_seq.sv
// PCI target transaction sequencer.
// Tracks one PCI transaction from the address phase to turnaround and drives
// the target handshake signals: normal completion, burst transfer, retry after
// a wait timeout, target abort and configuration disconnect-after-one-phase.
// Ports:
//   clk, rst        PCI clock; asynchronous active-high reset
//   frame_n, irdy_n sampled initiator FRAME# / IRDY#
//   card_hit        address decode hit, valid in the decode clock
//   acc_cfg         access is a configuration cycle
//   cfg_drdy        config register data ready
//   be_drdy         memory/IO backend data ready
//   t_abort         backend requests target abort
//   first_cyc       address-phase clock indicator (combinational)
//   acc_end         one-clock pulse when the transaction ends
//   xfer            data transferred this clock (combinational)
//   devsel_n, trdy_n, stop_n  registered target signals, active-low
//   tgt_oe          output enable for devsel_n/trdy_n/stop_n
module pci_tgt_seq
  import pci_tgt_seq_pkg::*;
#(
  parameter int unsigned RETRY_LIMIT = RETRY_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_n,
  input  logic irdy_n,
  input  logic card_hit,
  input  logic acc_cfg,
  input  logic cfg_drdy,
  input  logic be_drdy,
  input  logic t_abort,
  output logic first_cyc,
  output logic acc_end,
  output logic xfer,
  output logic devsel_n,
  output logic trdy_n,
  output logic stop_n,
  output logic tgt_oe
);

  tgt_state_e       state, state_nxt;
  tgt_drv_t         drv, drv_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             seen, seen_nxt;
  logic             frame_q;
  logic             acc_end_nxt;
  logic             drdy;

  assign devsel_n = drv.devsel_n;
  assign trdy_n   = drv.trdy_n;
  assign stop_n   = drv.stop_n;
  assign tgt_oe   = drv.oe;

  // Address phase: falling edge of FRAME# seen while idle; masked in reset.
  assign first_cyc = (state == IDLE) & ~frame_n & frame_q & ~rst;

  // A data phase completes whenever both ready signals are low.
  assign xfer = ~drv.trdy_n & ~irdy_n;

  // State, driver and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      drv     <= DRV_OFF;
      cnt     <= '0;
      seen    <= 1'b0;
      frame_q <= 1'b1;
      acc_end <= 1'b0;
    end else begin
      state   <= state_nxt;
      drv     <= drv_nxt;
      cnt     <= cnt_nxt;
      seen    <= seen_nxt;
      frame_q <= frame_n;
      acc_end <= acc_end_nxt;
    end
  end

  // Next-state and next-driver logic.
  always_comb begin
    state_nxt   = state;
    drv_nxt     = drv;
    cnt_nxt     = '0;
    seen_nxt    = seen;
    acc_end_nxt = 1'b0;
    drdy        = acc_cfg ? cfg_drdy : be_drdy;
    cnt_inc     = sat_inc(cnt);

    unique case (state)
      IDLE: begin
        drv_nxt  = DRV_OFF;
        seen_nxt = 1'b0;
        if (!frame_n && frame_q) begin
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        if (card_hit) begin
          state_nxt        = DATA;
          drv_nxt.devsel_n = 1'b0;
          drv_nxt.oe       = 1'b1;
        end else begin
          state_nxt = BUSY;
        end
      end

      // Not our transaction: wait for the bus to go idle.
      BUSY: begin
        drv_nxt = DRV_OFF;
        if (frame_n && irdy_n) begin
          state_nxt = IDLE;
        end
      end

      DATA: begin
        // Wait counter restarts on every completed data phase.
        cnt_nxt  = xfer ? '0 : cnt_inc;
        seen_nxt = seen | xfer;
        if (t_abort) begin
          state_nxt        = BACKOFF;
          drv_nxt.devsel_n = 1'b1;
          drv_nxt.trdy_n   = 1'b1;
          drv_nxt.stop_n   = 1'b0;
        end else if (xfer && frame_n) begin
          state_nxt   = TURN_AR;
          drv_nxt     = DRV_TURN;
          acc_end_nxt = 1'b1;
        end else if (xfer && acc_cfg) begin
          // Config accesses are single-phase: disconnect a continuing burst.
          state_nxt      = BACKOFF;
          drv_nxt.trdy_n = 1'b1;
          drv_nxt.stop_n = 1'b0;
        end else if (!seen && drv.trdy_n && (cnt_inc == CNT_W'(RETRY_LIMIT))) begin
          // Retry only while uncommitted: once TRDY# is out the phase must finish.
          state_nxt      = BACKOFF;
          drv_nxt.trdy_n = 1'b1;
          drv_nxt.stop_n = 1'b0;
        end else if (xfer || drv.trdy_n) begin
          drv_nxt.trdy_n = ~drdy;
        end
      end

      // Hold STOP# until the initiator finishes its last phase.
      BACKOFF: begin
        if (frame_n && !irdy_n) begin
          state_nxt   = TURN_AR;
          drv_nxt     = DRV_TURN;
          acc_end_nxt = 1'b1;
        end
      end

      TURN_AR: begin
        state_nxt = IDLE;
        drv_nxt   = DRV_OFF;
      end

      default: begin
        state_nxt = IDLE;
        drv_nxt   = DRV_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_pci_tgt_seq.sv
// Directed bench for pci_tgt_seq: reset, config read, memory burst, retry,
// target abort, decode miss, config disconnect and reset mid-burst.
module tb_pci_tgt_seq;

  logic clk = 1'b0;
  logic rst, frame_n, irdy_n, card_hit, acc_cfg, cfg_drdy, be_drdy, t_abort;
  logic first_cyc, acc_end, xfer, devsel_n, trdy_n, stop_n, tgt_oe;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pci_tgt_seq #(.RETRY_LIMIT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .card_hit (card_hit),
    .acc_cfg  (acc_cfg),
    .cfg_drdy (cfg_drdy),
    .be_drdy  (be_drdy),
    .t_abort  (t_abort),
    .first_cyc(first_cyc),
    .acc_end  (acc_end),
    .xfer     (xfer),
    .devsel_n (devsel_n),
    .trdy_n   (trdy_n),
    .stop_n   (stop_n),
    .tgt_oe   (tgt_oe)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_drv(input string tag, input logic dv, input logic tr,
                         input logic st, input logic oe);
    chk({tag, ".devsel_n"}, devsel_n, dv);
    chk({tag, ".trdy_n"},   trdy_n,   tr);
    chk({tag, ".stop_n"},   stop_n,   st);
    chk({tag, ".tgt_oe"},   tgt_oe,   oe);
  endtask

  task automatic bus(input logic f, input logic i);
    frame_n = f;
    irdy_n  = i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_n = 1'b0; irdy_n = 1'b1; card_hit = 1'b0;
    acc_cfg = 1'b0; cfg_drdy = 1'b0; be_drdy = 1'b0; t_abort = 1'b0;

    // Reset values, with FRAME# low to show first_cyc is masked
    tick(); tick(); settle();
    chk("rst.first_cyc", first_cyc, 1'b0);
    chk_drv("rst", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst.acc_end", acc_end, 1'b0);
    chk("rst.xfer", xfer, 1'b0);
    frame_n = 1'b1;
    tick(); rst = 1'b0;
    tick();

    // Config read, single data phase
    tick(); bus(1'b0, 1'b1); acc_cfg = 1'b1; settle();
    chk("a.first_cyc", first_cyc, 1'b1);
    chk_drv("a.addr", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(); bus(1'b1, 1'b0); card_hit = 1'b1; settle();
    chk("a.dec.first_cyc", first_cyc, 1'b0);
    chk("a.dec.devsel_n", devsel_n, 1'b1);
    tick(); card_hit = 1'b0; cfg_drdy = 1'b1; settle();
    chk_drv("a.data", 1'b0, 1'b1, 1'b1, 1'b1);
    chk("a.data.xfer", xfer, 1'b0);
    tick(); cfg_drdy = 1'b0; settle();
    chk("a.xfer", xfer, 1'b1);
    chk_drv("a.xfer", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); bus(1'b1, 1'b1); settle();
    chk("a.turn.acc_end", acc_end, 1'b1);
    chk("a.turn.xfer", xfer, 1'b0);
    chk_drv("a.turn", 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); settle();
    chk("a.idle.acc_end", acc_end, 1'b0);
    chk("a.idle.tgt_oe", tgt_oe, 1'b0);

    // Memory burst of four, backend always ready
    tick(); bus(1'b0, 1'b1); acc_cfg = 1'b0; be_drdy = 1'b1; settle();
    chk("b.first_cyc", first_cyc, 1'b1);
    tick(); bus(1'b0, 1'b0); card_hit = 1'b1; settle();
    tick(); card_hit = 1'b0; settle();
    chk("b.data.xfer", xfer, 1'b0);
    chk_drv("b.data", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) frame_n = 1'b1;
      settle();
      chk($sformatf("b.xfer%0d", k), xfer, 1'b1);
      chk($sformatf("b.stop%0d", k), stop_n, 1'b1);
    end
    tick(); bus(1'b1, 1'b1); be_drdy = 1'b0; settle();
    chk("b.turn.acc_end", acc_end, 1'b1);
    chk("b.turn.xfer", xfer, 1'b0);
    chk("b.turn.stop_n", stop_n, 1'b1);
    tick(); settle();
    chk("b.idle.tgt_oe", tgt_oe, 1'b0);

    // Backend never ready: retry after 16 data clocks
    tick(); bus(1'b0, 1'b1); settle();
    chk("c.first_cyc", first_cyc, 1'b1);
    tick(); bus(1'b0, 1'b0); card_hit = 1'b1; settle();
    tick(); card_hit = 1'b0; settle();
    chk("c.wait0.stop_n", stop_n, 1'b1);
    for (int k = 1; k < 16; k++) begin
      tick(); settle();
      chk($sformatf("c.wait%0d.stop_n", k), stop_n, 1'b1);
      chk($sformatf("c.wait%0d.xfer", k), xfer, 1'b0);
    end
    tick(); settle();
    chk_drv("c.retry", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("c.retry.xfer", xfer, 1'b0);
    tick(); settle();
    chk("c.hold.stop_n", stop_n, 1'b0);
    tick(); bus(1'b1, 1'b0); settle();
    chk("c.last.stop_n", stop_n, 1'b0);
    tick(); bus(1'b1, 1'b1); settle();
    chk("c.turn.acc_end", acc_end, 1'b1);
    chk_drv("c.turn", 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); settle();
    chk("c.idle.tgt_oe", tgt_oe, 1'b0);

    // Target abort wins over data ready in the same clock
    tick(); bus(1'b0, 1'b1); settle();
    chk("d.first_cyc", first_cyc, 1'b1);
    tick(); bus(1'b0, 1'b0); card_hit = 1'b1; settle();
    tick(); card_hit = 1'b0; be_drdy = 1'b1; t_abort = 1'b1; settle();
    chk("d.req.xfer", xfer, 1'b0);
    tick(); t_abort = 1'b0; be_drdy = 1'b0; bus(1'b1, 1'b0); settle();
    chk_drv("d.abort", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("d.abort.xfer", xfer, 1'b0);
    tick(); bus(1'b1, 1'b1); settle();
    chk("d.turn.acc_end", acc_end, 1'b1);
    chk_drv("d.turn", 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); settle();
    chk("d.idle.tgt_oe", tgt_oe, 1'b0);

    // Decode miss: stay off the bus until FRAME# and IRDY# both high
    tick(); bus(1'b0, 1'b1); settle();
    chk("e.first_cyc", first_cyc, 1'b1);
    tick(); bus(1'b0, 1'b0); card_hit = 1'b0; settle();
    tick(); settle();
    chk_drv("e.busy", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(); bus(1'b1, 1'b0); settle();
    chk("e.busy2.tgt_oe", tgt_oe, 1'b0);
    tick(); bus(1'b0, 1'b1); settle();
    chk("e.still_busy.first_cyc", first_cyc, 1'b0);
    chk("e.still_busy.tgt_oe", tgt_oe, 1'b0);
    tick(); bus(1'b1, 1'b1); settle();
    tick(); settle();
    chk("e.idle.tgt_oe", tgt_oe, 1'b0);

    // Config access with FRAME# still low: disconnect after one phase
    tick(); bus(1'b0, 1'b1); acc_cfg = 1'b1; settle();
    chk("g.first_cyc", first_cyc, 1'b1);
    tick(); bus(1'b0, 1'b0); card_hit = 1'b1; settle();
    tick(); card_hit = 1'b0; cfg_drdy = 1'b1; settle();
    chk("g.data.xfer", xfer, 1'b0);
    tick(); cfg_drdy = 1'b0; settle();
    chk("g.xfer", xfer, 1'b1);
    chk("g.xfer.stop_n", stop_n, 1'b1);
    tick(); settle();
    chk_drv("g.disc", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("g.disc.xfer", xfer, 1'b0);
    tick(); bus(1'b1, 1'b0); settle();
    chk("g.last.stop_n", stop_n, 1'b0);
    tick(); bus(1'b1, 1'b1); settle();
    chk("g.turn.acc_end", acc_end, 1'b1);
    tick(); acc_cfg = 1'b0; settle();
    chk("g.idle.tgt_oe", tgt_oe, 1'b0);

    // Reset in the second data clock of a burst
    tick(); bus(1'b0, 1'b1); be_drdy = 1'b1; settle();
    chk("f.first_cyc", first_cyc, 1'b1);
    tick(); bus(1'b0, 1'b0); card_hit = 1'b1; settle();
    tick(); card_hit = 1'b0; settle();
    chk("f.data1.tgt_oe", tgt_oe, 1'b1);
    tick(); settle();
    chk("f.data2.xfer", xfer, 1'b1);
    #1; rst = 1'b1; #1;
    chk_drv("f.rst", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("f.rst.xfer", xfer, 1'b0);
    chk("f.rst.acc_end", acc_end, 1'b0);
    tick(); settle();
    chk("f.rst_hold.acc_end", acc_end, 1'b0);
    chk("f.rst_hold.tgt_oe", tgt_oe, 1'b0);
    bus(1'b1, 1'b1); be_drdy = 1'b0; rst = 1'b0;
    tick(); settle();
    chk("f.after.acc_end", acc_end, 1'b0);
    chk("f.after.tgt_oe", tgt_oe, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
